egress_burst: RTL and testbench

Parametrised burst-capable egress bridge between the internal bus and the external egress port.
- Takes one address beat from the internal side: address plus read/write flag plus burst length.
- For writes, forwards 1..2^BLW data beats through a one-entry registered output stage with valid/ready flow control.
- For reads, collects the same number of returned beats and hands them back to the internal side.
- Sits between the internal bridge and the external pins.

---
 rtl/egress_burst.sv | 186 ++++++++++++++++++
 tb/tb_egress_burst.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/egress_burst.sv
// egress_burst: burst-capable bridge from the internal bus to the egress port.
// One address beat (rw in bit DW-1, burst length) then 1..2^BLW data beats.
// Ports:
//   clk, rstN            clock, synchronous active-low reset
//   int_datavalid/rdy    internal beat handshake (int2eg_data, int_burstlen)
//   eg2int_data/valid    read data pulse back to internal side, _last on final
//   eg_ad_dataout/valid  registered address/write beat to external port
//   eg_last, eg_ready    final write beat flag, external consume strobe
//   eg_datain, eg_rvalid external read data
//   eg_busy, eg_timeout  not idle, one-cycle stall abort pulse
// Optional: define EGB_TIMEOUT_EN to enable the stall watchdog (TIMEOUT cycles).
module egress_burst #(
  parameter int DW      = 8,
  parameter int BLW     = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          int_datavalid,
  input  logic [DW-1:0] int2eg_data,
  input  logic [BLW-1:0] int_burstlen,
  output logic          int_datardy,
  output logic [DW-1:0] eg2int_data,
  output logic          eg2int_valid,
  output logic          eg2int_last,
  output logic [DW-1:0] eg_ad_dataout,
  output logic          eg_valid,
  output logic          eg_last,
  input  logic          eg_ready,
  input  logic [DW-1:0] eg_datain,
  input  logic          eg_rvalid,
  output logic          eg_busy,
  output logic          eg_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WDATA,
    RDATA
  } state_t;

  localparam logic [BLW:0] ONE = 1;

  state_t         state;
  logic           rw;
  logic [BLW-1:0] len;
  logic [BLW:0]   lcnt;
  logic [BLW:0]   rcnt;
  logic           pop;
  logic           accept;
  logic           abort;

  assign pop     = eg_valid && eg_ready;
  assign accept  = int_datavalid && int_datardy;
  assign eg_busy = (state != IDLE);
  assign eg_last = (state == WDATA) && eg_valid && (lcnt == '0);

  always_comb begin
    int_datardy = 1'b0;
    unique case (state)
      IDLE:    int_datardy = 1'b1;
      ADDR:    int_datardy = !rw && eg_ready;
      WDATA:   int_datardy = (lcnt != '0) && (!eg_valid || eg_ready);
      RDATA:   int_datardy = 1'b0;
      default: int_datardy = 1'b0;
    endcase
  end

`ifdef EGB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);

  logic [SW-1:0] scnt;
  logic          stall;
  logic          tmo;

  // A stall is a cycle where the active side makes no progress.
  always_comb begin
    stall = 1'b0;
    unique case (state)
      ADDR, WDATA: stall = eg_valid && !eg_ready;
      RDATA:       stall = !eg_rvalid;
      default:     stall = 1'b0;
    endcase
  end

  assign abort = stall && (scnt == SW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rstN) begin
      scnt <= '0;
      tmo  <= 1'b0;
    end else begin
      tmo <= abort;
      if (!stall || abort)
        scnt <= '0;
      else
        scnt <= scnt + 1'b1;
    end
  end

  assign eg_timeout = tmo;
`else
  assign abort      = 1'b0;
  assign eg_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state         <= IDLE;
      rw            <= 1'b0;
      len           <= '0;
      lcnt          <= '0;
      rcnt          <= '0;
      eg_valid      <= 1'b0;
      eg_ad_dataout <= '0;
      eg2int_data   <= '0;
      eg2int_valid  <= 1'b0;
      eg2int_last   <= 1'b0;
    end else begin
      eg2int_valid <= 1'b0;
      eg2int_last  <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        eg_valid <= 1'b0;
        lcnt     <= '0;
        rcnt     <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              eg_ad_dataout <= int2eg_data;
              eg_valid      <= 1'b1;
              rw            <= int2eg_data[DW-1];
              len           <= int_burstlen;
              lcnt          <= {1'b0, int_burstlen} + ONE;
              state         <= ADDR;
            end
          end
          ADDR: begin
            if (pop) begin
              if (rw) begin
                eg_valid <= 1'b0;
                rcnt     <= {1'b0, len} + ONE;
                state    <= RDATA;
              end else begin
                state <= WDATA;
                // First data beat may ride the address pop.
                if (int_datavalid) begin
                  eg_ad_dataout <= int2eg_data;
                  lcnt          <= lcnt - ONE;
                end else begin
                  eg_valid <= 1'b0;
                end
              end
            end
          end
          WDATA: begin
            if (pop && eg_last) begin
              eg_valid <= 1'b0;
              state    <= IDLE;
            end else if (accept) begin
              eg_ad_dataout <= int2eg_data;
              eg_valid      <= 1'b1;
              lcnt          <= lcnt - ONE;
            end else if (pop) begin
              eg_valid <= 1'b0;
            end
          end
          RDATA: begin
            if (eg_rvalid) begin
              eg2int_data  <= eg_datain;
              eg2int_valid <= 1'b1;
              eg2int_last  <= (rcnt == ONE);
              rcnt         <= rcnt - ONE;
              if (rcnt == ONE)
                state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_egress_burst.sv
// tb_egress_burst: directed self-checking bench for egress_burst.
// Logs egress pops and read-return pulses, compares against hand values.
module tb_egress_burst;

`ifdef EGB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       int_datavalid = 1'b0;
  logic [7:0] int2eg_data = '0;
  logic [3:0] int_burstlen = '0;
  logic       int_datardy;
  logic [7:0] eg2int_data;
  logic       eg2int_valid;
  logic       eg2int_last;
  logic [7:0] eg_ad_dataout;
  logic       eg_valid;
  logic       eg_last;
  logic       eg_ready = 1'b0;
  logic [7:0] eg_datain = '0;
  logic       eg_rvalid = 1'b0;
  logic       eg_busy;
  logic       eg_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] wlog_d[$];
  logic       wlog_l[$];
  logic [7:0] rlog_d[$];
  logic       rlog_l[$];

  always #5 clk = ~clk;

  egress_burst #(.DW(8), .BLW(4), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rstN(rstN),
    .int_datavalid(int_datavalid),
    .int2eg_data(int2eg_data),
    .int_burstlen(int_burstlen),
    .int_datardy(int_datardy),
    .eg2int_data(eg2int_data),
    .eg2int_valid(eg2int_valid),
    .eg2int_last(eg2int_last),
    .eg_ad_dataout(eg_ad_dataout),
    .eg_valid(eg_valid),
    .eg_last(eg_last),
    .eg_ready(eg_ready),
    .eg_datain(eg_datain),
    .eg_rvalid(eg_rvalid),
    .eg_busy(eg_busy),
    .eg_timeout(eg_timeout)
  );

  always @(negedge clk) begin
    if (rstN) begin
      if (eg_valid && eg_ready) begin
        wlog_d.push_back(eg_ad_dataout);
        wlog_l.push_back(eg_last);
      end
      if (eg2int_valid) begin
        rlog_d.push_back(eg2int_data);
        rlog_l.push_back(eg2int_last);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(eg_valid), 0);
    chk({tag, "_last"}, 32'(eg_last), 0);
    chk({tag, "_dout"}, 32'(eg_ad_dataout), 0);
    chk({tag, "_rdata"}, 32'(eg2int_data), 0);
    chk({tag, "_rvalid"}, 32'(eg2int_valid), 0);
    chk({tag, "_rlast"}, 32'(eg2int_last), 0);
    chk({tag, "_tmo"}, 32'(eg_timeout), 0);
    chk({tag, "_busy"}, 32'(eg_busy), 0);
  endtask

  task automatic run_write(input logic [7:0] addr, input int n,
                           input logic [7:0] base, input logic [7:0] stp,
                           input bit tog, input int stop_at,
                           output int cyc);
    int  idx;
    bit  hs;
    idx = -1;
    cyc = 0;
    wlog_d.delete();
    wlog_l.delete();
    int_burstlen = 4'(n - 1);
    while (cyc < 300) begin
      if (idx == n && !eg_busy) break;
      eg_ready = tog ? (cyc % 2 == 0) : 1'b1;
      int_datavalid = (idx < n);
      int2eg_data = (idx < 0) ? addr : 8'(base + stp * idx);
      #1;
      hs = int_datavalid && int_datardy;
      step();
      cyc++;
      if (hs) idx++;
      if (idx == stop_at) break;
    end
    int_datavalid = 1'b0;
    eg_ready = 1'b0;
    chk("wr_bound", 32'(cyc < 300), 1);
  endtask

  task automatic chk_wlog(input logic [7:0] addr, input int n,
                          input logic [7:0] base, input logic [7:0] stp);
    chk("wlog_cnt", 32'(wlog_d.size()), 32'(n + 1));
    if (wlog_d.size() == n + 1) begin
      chk("wlog_addr", 32'(wlog_d[0]), 32'(addr));
      chk("wlog_alast", 32'(wlog_l[0]), 0);
      for (int i = 0; i < n; i++) begin
        chk("wlog_data", 32'(wlog_d[i+1]), 32'(8'(base + stp * i)));
        chk("wlog_last", 32'(wlog_l[i+1]), 32'(i == n - 1));
      end
    end
  endtask

  logic [7:0] rv_d[4];
  logic       rv_v[4];
  int         cyc;

  initial begin
    rv_d[0] = 8'hC1; rv_v[0] = 1'b1;
    rv_d[1] = 8'h00; rv_v[1] = 1'b0;
    rv_d[2] = 8'hC2; rv_v[2] = 1'b1;
    rv_d[3] = 8'hC3; rv_v[3] = 1'b1;

    step();
    step();
    chk_zero("rst");
    chk("rst_rdy", 32'(int_datardy), 1);
    rstN = 1'b1;

    // single write
    run_write(8'h15, 1, 8'hA5, 8'h00, 1'b0, -2, cyc);
    chk_wlog(8'h15, 1, 8'hA5, 8'h00);
    chk("w1_cyc", 32'(cyc), 3);
    chk("w1_busy", 32'(eg_busy), 0);
    chk("w1_hold", 32'(eg_ad_dataout), 32'h A5);

    // burst of 4 with eg_ready toggling
    run_write(8'h20, 4, 8'h11, 8'h11, 1'b1, -2, cyc);
    chk_wlog(8'h20, 4, 8'h11, 8'h11);
    chk("w4_busy", 32'(eg_busy), 0);

    // eg_rvalid while idle must be ignored
    rlog_d.delete();
    rlog_l.delete();
    eg_rvalid = 1'b1;
    eg_datain = 8'h77;
    step();
    eg_rvalid = 1'b0;
    step();
    chk("idle_rv", 32'(rlog_d.size()), 0);

    // read burst of 3
    int_datavalid = 1'b1;
    int2eg_data = 8'h85;
    int_burstlen = 4'd2;
    eg_ready = 1'b1;
    step();
    int_datavalid = 1'b0;
    #1;
    chk("rd_addr_out", 32'(eg_ad_dataout), 32'h85);
    chk("rd_addr_rdy", 32'(int_datardy), 0);
    step();
    eg_ready = 1'b0;
    chk("rd_valid", 32'(eg_valid), 0);
    chk("rd_busy", 32'(eg_busy), 1);
    for (int i = 0; i < 4; i++) begin
      eg_rvalid = rv_v[i];
      eg_datain = rv_d[i];
      #1;
      chk("rd_rdy", 32'(int_datardy), 0);
      step();
    end
    eg_rvalid = 1'b0;
    step();
    chk("rd_cnt", 32'(rlog_d.size()), 3);
    if (rlog_d.size() == 3) begin
      chk("rd_d0", 32'(rlog_d[0]), 32'h C1);
      chk("rd_d1", 32'(rlog_d[1]), 32'h C2);
      chk("rd_d2", 32'(rlog_d[2]), 32'h C3);
      chk("rd_l0", 32'(rlog_l[0]), 0);
      chk("rd_l1", 32'(rlog_l[1]), 0);
      chk("rd_l2", 32'(rlog_l[2]), 1);
    end
    chk("rd_hold", 32'(eg2int_data), 32'h C3);
    chk("rd_busy_end", 32'(eg_busy), 0);

    // max burst, back-to-back
    run_write(8'h3F, 16, 8'h40, 8'h01, 1'b0, -2, cyc);
    chk_wlog(8'h3F, 16, 8'h40, 8'h01);
    chk("w16_cyc", 32'(cyc), 18);

    // reset mid-burst after two data beats accepted
    run_write(8'h01, 8, 8'h90, 8'h01, 1'b0, 2, cyc);
    chk("mid_busy", 32'(eg_busy), 1);
    rstN = 1'b0;
    step();
    chk_zero("mid_rst");
    rstN = 1'b1;
    step();
    run_write(8'h2A, 1, 8'h5C, 8'h00, 1'b0, -2, cyc);
    chk_wlog(8'h2A, 1, 8'h5C, 8'h00);
    chk("post_rst_cyc", 32'(cyc), 3);

    // stall in ADDR with eg_ready held low
    int_datavalid = 1'b1;
    int2eg_data = 8'h10;
    int_burstlen = 4'd0;
    eg_ready = 1'b0;
    step();
    int_datavalid = 1'b0;
`ifdef EGB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_wait", 32'(eg_timeout), 0);
      chk("to_wbusy", 32'(eg_busy), 1);
    end
    step();
    chk("to_pulse", 32'(eg_timeout), 1);
    chk("to_valid", 32'(eg_valid), 0);
    chk("to_busy", 32'(eg_busy), 0);
    step();
    chk("to_once", 32'(eg_timeout), 0);
`else
    for (int i = 0; i < 10; i++) step();
    chk("st_tmo", 32'(eg_timeout), 0);
    chk("st_busy", 32'(eg_busy), 1);
    chk("st_valid", 32'(eg_valid), 1);
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    chk("st_rst", 32'(eg_busy), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
